// File: rtl/tnn_pkg.sv
// Shared definitions for the streaming ternary classifier: FSM states,
// accumulator/score width helpers and the default layer-2 sparsity pattern.
package tnn_pkg;

  typedef enum logic [1:0] {IDLE, HIDDEN, CLASS, DONE} state_t;

  localparam int DEF_FEAT_CNT   = 16;
  localparam int DEF_HIDDEN_CNT = 40;
  localparam int DEF_CLASS_CNT  = 10;
  localparam int DEF_NNZ2       = 208;
  localparam int DEF_CIDX_W     = 8;
  localparam int DEF_PTR_W      = 8;

  function automatic int acc_width(input int feat_bits, input int feat_cnt);
    return feat_bits + $clog2(feat_cnt) + 1;
  endfunction

  function automatic int score_width(input int hidden_cnt);
    return $clog2(hidden_cnt + 1) + 1;
  endfunction

  // Default columns are spread evenly over the hidden layer.
  function automatic logic [DEF_NNZ2*DEF_CIDX_W-1:0] def_col_indices();
    logic [DEF_NNZ2*DEF_CIDX_W-1:0] v;
    v = '0;
    for (int p = 0; p < DEF_NNZ2; p++)
      v[p*DEF_CIDX_W +: DEF_CIDX_W] = DEF_CIDX_W'((p * 7 + 3) % DEF_HIDDEN_CNT);
    return v;
  endfunction

  function automatic logic [(DEF_CLASS_CNT+1)*DEF_PTR_W-1:0] def_row_ptrs();
    logic [(DEF_CLASS_CNT+1)*DEF_PTR_W-1:0] v;
    v = '0;
    for (int c = 0; c <= DEF_CLASS_CNT; c++)
      v[c*DEF_PTR_W +: DEF_PTR_W] = DEF_PTR_W'((c * DEF_NNZ2) / DEF_CLASS_CNT);
    return v;
  endfunction

endpackage

// File: rtl/tnn_hidden_unit.sv
// One ternary hidden neuron: masked, signed sum of unsigned features,
// thresholded at zero (zero maps to +1).
module tnn_hidden_unit #(
  parameter int FEAT_CNT  = 16,
  parameter int FEAT_BITS = 4,
  parameter int ACC_W     = tnn_pkg::acc_width(FEAT_BITS, FEAT_CNT)
) (
  input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [FEAT_CNT-1:0]           mask,
  input  logic [FEAT_CNT-1:0]           sign_bits,
  output logic                          hbit
);

  logic signed [ACC_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int f = 0; f < FEAT_CNT; f++) begin
      if (mask[f]) begin
        if (sign_bits[f]) acc = acc + ACC_W'(features[f*FEAT_BITS +: FEAT_BITS]);
        else              acc = acc - ACC_W'(features[f*FEAT_BITS +: FEAT_BITS]);
      end
    end
  end

  assign hbit = ~acc[ACC_W-1];

endmodule

// File: rtl/seq_tnn_stream.sv
// Sequential ternary classifier with valid/ready streaming: dense masked layer 1
// (HID_PAR neurons per cycle) followed by CSR sparse layer 2 (one nonzero per cycle).
module seq_tnn_stream
  import tnn_pkg::*;
#(
  parameter int FEAT_CNT   = DEF_FEAT_CNT,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = DEF_HIDDEN_CNT,
  parameter int CLASS_CNT  = DEF_CLASS_CNT,
  parameter int HID_PAR    = 4,
  parameter int NNZ2       = DEF_NNZ2,
  parameter int CIDX_W     = DEF_CIDX_W,
  parameter int PTR_W      = DEF_PTR_W,
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  MASK        = {20{32'hB7E1_5163}},
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  SIGN1       = {20{32'h9E37_79B9}},
  parameter logic [NNZ2-1:0]                 SIGN2       = {13{16'hC3A5}},
  parameter logic [NNZ2*CIDX_W-1:0]          COL_INDICES = def_col_indices(),
  parameter logic [(CLASS_CNT+1)*PTR_W-1:0]  ROW_PTRS    = def_row_ptrs()
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]  prediction,
  output logic                          busy
);

  localparam int ACC_W    = acc_width(FEAT_BITS, FEAT_CNT);
  localparam int SCORE_W  = score_width(HIDDEN_CNT);
  localparam int PRED_W   = $clog2(CLASS_CNT);
  localparam int IDX_W    = $clog2(HIDDEN_CNT + 1);
  localparam int STEPS    = HIDDEN_CNT / HID_PAR;
  localparam int LAST_IDX = HIDDEN_CNT - HID_PAR;
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  state_t                        state_reg;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_reg;
  logic [HIDDEN_CNT-1:0]         hid_reg;
  logic [IDX_W-1:0]              hid_idx_reg;
  logic [PTR_W-1:0]              p_reg;
  logic [PRED_W-1:0]             c_reg, best_idx_reg, prediction_reg;
  logic signed [SCORE_W-1:0]     score_reg, best_reg;
  logic                          in_ready_reg, out_valid_reg, busy_reg;
  logic [HID_PAR-1:0]            hbits;

  genvar gi;
  generate
    for (gi = 0; gi < HID_PAR; gi++) begin : g_unit
      logic [FEAT_CNT-1:0] mask_sel, sign_sel;

      // Neuron hid_idx+gi: weight rows selected from the constant tables.
      always_comb begin
        mask_sel = '0;
        sign_sel = '0;
        for (int s = 0; s < STEPS; s++) begin
          if (hid_idx_reg == IDX_W'(s * HID_PAR)) begin
            mask_sel = MASK[(s*HID_PAR + gi)*FEAT_CNT +: FEAT_CNT];
            sign_sel = SIGN1[(s*HID_PAR + gi)*FEAT_CNT +: FEAT_CNT];
          end
        end
      end

      tnn_hidden_unit #(.FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS), .ACC_W(ACC_W)) u_unit (
        .features (feat_reg),
        .mask     (mask_sel),
        .sign_bits(sign_sel),
        .hbit     (hbits[gi])
      );
    end
  endgenerate

  logic [PTR_W-1:0]  row_end;
  logic [CIDX_W-1:0] col;
  logic              sign2_bit, hid_bit;

  always_comb begin
    row_end   = '0;
    col       = '0;
    sign2_bit = 1'b0;
    hid_bit   = 1'b0;
    for (int c = 0; c < CLASS_CNT; c++)
      if (c_reg == PRED_W'(c)) row_end = ROW_PTRS[(c+1)*PTR_W +: PTR_W];
    for (int q = 0; q < NNZ2; q++) begin
      if (p_reg == PTR_W'(q)) begin
        col       = COL_INDICES[q*CIDX_W +: CIDX_W];
        sign2_bit = SIGN2[q];
      end
    end
    for (int h = 0; h < HIDDEN_CNT; h++)
      if (col == CIDX_W'(h)) hid_bit = hid_reg[h];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      feat_reg       <= '0;
      hid_reg        <= '0;
      hid_idx_reg    <= '0;
      p_reg          <= '0;
      c_reg          <= '0;
      score_reg      <= '0;
      best_reg       <= SCORE_MIN;
      best_idx_reg   <= '0;
      prediction_reg <= '0;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            feat_reg     <= features;
            hid_idx_reg  <= '0;
            state_reg    <= HIDDEN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        HIDDEN: begin
          for (int h = 0; h < HIDDEN_CNT; h++)
            if (int'(hid_idx_reg) == h - (h % HID_PAR)) hid_reg[h] <= hbits[h % HID_PAR];
          if (hid_idx_reg == IDX_W'(LAST_IDX)) begin
            state_reg    <= CLASS;
            hid_idx_reg  <= '0;
            p_reg        <= '0;
            c_reg        <= '0;
            score_reg    <= '0;
            best_reg     <= SCORE_MIN;
            best_idx_reg <= '0;
          end else begin
            hid_idx_reg <= hid_idx_reg + IDX_W'(HID_PAR);
          end
        end
        CLASS: begin
          if (p_reg == row_end) begin
            // Strict compare keeps the lowest class index on ties.
            if (score_reg > best_reg) begin
              best_reg     <= score_reg;
              best_idx_reg <= c_reg;
            end
            score_reg <= '0;
            if (c_reg == PRED_W'(CLASS_CNT - 1)) begin
              prediction_reg <= (score_reg > best_reg) ? c_reg : best_idx_reg;
              state_reg      <= DONE;
              out_valid_reg  <= 1'b1;
              busy_reg       <= 1'b0;
            end else begin
              c_reg <= c_reg + PRED_W'(1);
            end
          end else begin
            score_reg <= (sign2_bit ~^ hid_bit) ? score_reg + SCORE_W'(1) : score_reg - SCORE_W'(1);
            p_reg     <= p_reg + PTR_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign busy       = busy_reg;
  assign prediction = prediction_reg;

endmodule
